// File: rtl/alu_operand_issue.sv
// -----------------------------------------------------------------------------
// alu_operand_issue
//
// This is the issue stage that sits just ahead of the execute ALU. It registers
// the opcode and both operands. Data_2 is taken either from the register source
// or from the immediate. The stage holds these values stable until the
// downstream consumer accepts them, using a valid/ready handshake.
//
// DIV (3) and MOD (4) feed a combinational divider. For these opcodes the stage
// keeps the operands stable for DIV_WAIT_CYCLES cycles before it raises
// Out_Valid.
//
// Optional build macro: DIV_ZERO_TRAP_EN
//   When it is defined, a DIV/MOD whose selected Data_2 is zero issues as a NOP
//   (17). That op skips the settle wait and sets the sticky Div_Zero flag.
//
// Parameters:
//   DIV_WAIT_CYCLES  number of cycles before valid for ops 3/4 (1..15, 1 = no wait)
//   CNT_W            width of the Issue_Count counter
//
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   In_Valid/In_Ready  upstream handshake
//   In_ALU_Op          opcode (5 bits)
//   In_Data_1/2, Imm   operands and immediate (32 bits)
//   Imm_Sel            1 selects Imm for Data_2
//   Out_Valid/Out_Ready downstream handshake
//   ALU_Op, Data_1, Data_2  registered outputs to the ALU
//   Busy               stage holds an op that has not been consumed
//   Issue_Count        count of completed output handshakes (wraps)
//   Div_Zero           sticky divide-by-zero flag (DIV_ZERO_TRAP_EN only)
// -----------------------------------------------------------------------------
module alu_operand_issue #(
    parameter int DIV_WAIT_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [4:0]       In_ALU_Op,
    input  logic [31:0]      In_Data_1,
    input  logic [31:0]      In_Data_2,
    input  logic             Imm_Sel,
    input  logic [31:0]      Imm,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [4:0]       ALU_Op,
    output logic [31:0]      Data_1,
    output logic [31:0]      Data_2,
    output logic             Busy,
    output logic [CNT_W-1:0] Issue_Count
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic             Div_Zero
`endif
);

    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_NOP = 5'd17;

    // The wait counter is loaded with DIV_WAIT_CYCLES-1. HOLD is entered on the
    // edge where the counter leaves 1. As a result, Out_Valid rises exactly
    // DIV_WAIT_CYCLES cycles after the accept edge.
    localparam int         WAIT_INIT_I = (DIV_WAIT_CYCLES > 1) ? DIV_WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_INIT   = 4'(WAIT_INIT_I);
    localparam logic       HAS_WAIT    = (DIV_WAIT_CYCLES > 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_wait;
    logic [3:0]       w_wait_next;
    logic [4:0]       r_op;
    logic [31:0]      r_d1;
    logic [31:0]      r_d2;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_load;
    logic             w_fire;
    logic [31:0]      w_sel_d2;
    logic             w_is_div;
    logic             w_trap;
    logic             w_to_settle;
    logic [4:0]       w_load_op;

    // In_Ready depends only on the state and Out_Ready. It never depends on
    // In_Valid, which keeps the upstream path free of combinational loops.
    assign In_Ready  = !Reset && ((r_state == IDLE) || ((r_state == HOLD) && Out_Ready));
    assign w_accept  = In_Valid && In_Ready;
    assign w_sel_d2  = Imm_Sel ? Imm : In_Data_2;
    assign w_is_div  = (In_ALU_Op == OP_DIV) || (In_ALU_Op == OP_MOD);

`ifdef DIV_ZERO_TRAP_EN
    logic r_div_zero;
    assign w_trap   = w_is_div && (w_sel_d2 == 32'd0);
    assign Div_Zero = r_div_zero;
`else
    assign w_trap   = 1'b0;
`endif

    // A trapped divide becomes a NOP. A NOP has nothing to settle.
    assign w_load_op   = w_trap ? OP_NOP : In_ALU_Op;
    assign w_to_settle = w_is_div && !w_trap && HAS_WAIT;

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_load       = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_state_next = w_to_settle ? SETTLE : HOLD;
                    w_wait_next  = w_to_settle ? WAIT_INIT : 4'd0;
                end
            end
            SETTLE: begin
                // Out_Ready is deliberately ignored here.
                if (r_wait <= 4'd1) begin
                    w_state_next = HOLD;
                    w_wait_next  = 4'd0;
                end else begin
                    w_wait_next  = r_wait - 4'd1;
                end
            end
            HOLD: begin
                if (Out_Ready) begin
                    w_fire = 1'b1;
                    if (w_accept) begin
                        w_load       = 1'b1;
                        w_state_next = w_to_settle ? SETTLE : HOLD;
                        w_wait_next  = w_to_settle ? WAIT_INIT : 4'd0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_wait_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_wait  <= 4'd0;
            r_op    <= OP_NOP;
            r_d1    <= 32'd0;
            r_d2    <= 32'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_load) begin
                r_op <= w_load_op;
                r_d1 <= In_Data_1;
                r_d2 <= w_sel_d2;
            end
            if (w_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_div_zero <= 1'b0;
        end else if (w_load && w_trap) begin
            r_div_zero <= 1'b1;
        end
    end
`endif

    assign Out_Valid   = (r_state == HOLD);
    assign Busy        = (r_state != IDLE);
    assign ALU_Op      = r_op;
    assign Data_1      = r_d1;
    assign Data_2      = r_d2;
    assign Issue_Count = r_cnt;

endmodule

// File: tb/tb_alu_operand_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_issue
//
// Table-driven directed test for alu_operand_issue. It also runs hand-written
// sequences for the stall/back-to-back, reset-mid-settle and divide-by-zero
// cases. The bench uses the default parameters (DIV_WAIT_CYCLES=4, CNT_W=16).
// -----------------------------------------------------------------------------
module tb_alu_operand_issue;

    localparam int CNT_W = 16;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             In_Valid;
    logic             In_Ready;
    logic [4:0]       In_ALU_Op;
    logic [31:0]      In_Data_1;
    logic [31:0]      In_Data_2;
    logic             Imm_Sel;
    logic [31:0]      Imm;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [4:0]       ALU_Op;
    logic [31:0]      Data_1;
    logic [31:0]      Data_2;
    logic             Busy;
    logic [CNT_W-1:0] Issue_Count;
`ifdef DIV_ZERO_TRAP_EN
    logic             Div_Zero;
`endif

    always #5 Clock = ~Clock;

    alu_operand_issue #(.DIV_WAIT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .In_ALU_Op   (In_ALU_Op),
        .In_Data_1   (In_Data_1),
        .In_Data_2   (In_Data_2),
        .Imm_Sel     (Imm_Sel),
        .Imm         (Imm),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .ALU_Op      (ALU_Op),
        .Data_1      (Data_1),
        .Data_2      (Data_2),
        .Busy        (Busy),
        .Issue_Count (Issue_Count)
`ifdef DIV_ZERO_TRAP_EN
        ,
        .Div_Zero    (Div_Zero)
`endif
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        isel;
        logic [31:0] imm;
        logic [4:0]  exp_op;
        logic [31:0] exp_d2;
        int          exp_lat;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic isel, input logic [31:0] imm);
        In_Valid  = v;
        In_ALU_Op = op;
        In_Data_1 = d1;
        In_Data_2 = d2;
        Imm_Sel   = isel;
        Imm       = imm;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        exp_cnt = 0;
        chk("reset_in_ready", {31'd0, In_Ready}, 32'd0);
        Reset = 1'b0;
        #1;
    endtask

    vec_t vecs [7];

    initial begin
        Reset     = 1'b1;
        Out_Ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Directed vectors: each one is accepted, waited on, then consumed.
        vecs[0] = '{5'd0,  32'd5,   32'd7,     1'b0, 32'd0,          5'd0,  32'd7,          1};
        vecs[1] = '{5'd3,  32'd100, 32'd7,     1'b0, 32'd0,          5'd3,  32'd7,          4};
        vecs[2] = '{5'd18, 32'd1,   32'd1,     1'b1, 32'hDEADBEEF,   5'd18, 32'hDEADBEEF,   1};
        vecs[3] = '{5'd4,  32'd9,   32'd2,     1'b0, 32'd0,          5'd4,  32'd2,          4};
        vecs[4] = '{5'd25, 32'd3,   32'd4,     1'b0, 32'd0,          5'd25, 32'd4,          1};
        vecs[5] = '{5'd1,  32'd6,   32'd55,    1'b1, 32'd0,          5'd1,  32'd0,          1};
`ifdef DIV_ZERO_TRAP_EN
        vecs[6] = '{5'd3,  32'd8,   32'd0,     1'b0, 32'd0,          5'd17, 32'd0,          1};
`else
        vecs[6] = '{5'd3,  32'd8,   32'd0,     1'b0, 32'd0,          5'd3,  32'd0,          4};
`endif

        do_reset();
        chk("reset_alu_op", {27'd0, ALU_Op}, 32'd17);
        chk("reset_data_1", Data_1, 32'd0);
        chk("reset_data_2", Data_2, 32'd0);
        chk("reset_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_count", 32'(Issue_Count), 32'd0);
        chk("idle_in_ready", {31'd0, In_Ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            int lat;
            drive(1'b1, vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].isel, vecs[i].imm);
            Out_Ready = 1'b1;
            #1;
            chk("vec_in_ready", {31'd0, In_Ready}, 32'd1);
            tick();  // accept edge
            In_Valid = 1'b0;
            lat = 1;
            while (!Out_Valid && lat < 40) begin
                if (Busy) chk("settle_in_ready", {31'd0, In_Ready}, 32'd0);
                tick();
                lat++;
            end
            chk("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            chk("vec_alu_op", {27'd0, ALU_Op}, {27'd0, vecs[i].exp_op});
            chk("vec_data_1", Data_1, vecs[i].d1);
            chk("vec_data_2", Data_2, vecs[i].exp_d2);
            tick();  // handshake edge
            exp_cnt++;
            chk("vec_count", 32'(Issue_Count), 32'(exp_cnt));
            chk("vec_idle_valid", {31'd0, Out_Valid}, 32'd0);
            chk("vec_idle_busy", {31'd0, Busy}, 32'd0);
            $display("vec %0d op=%0d lat=%0d data_2=0x%0h count=%0d", i, vecs[i].op, lat, Data_2, Issue_Count);
        end

        // Stall: Out_Ready stays low while the input keeps changing.
        Out_Ready = 1'b0;
        drive(1'b1, 5'd2, 32'd11, 32'd22, 1'b0, 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'(5 + k), 32'(200 + k), 32'(300 + k), k[0], 32'(400 + k));
            #1;
            chk("stall_in_ready", {31'd0, In_Ready}, 32'd0);
            chk("stall_valid", {31'd0, Out_Valid}, 32'd1);
            chk("stall_alu_op", {27'd0, ALU_Op}, 32'd2);
            chk("stall_data_1", Data_1, 32'd11);
            chk("stall_data_2", Data_2, 32'd22);
            tick();
        end
        $display("stall held op=%0d d1=%0d d2=%0d", ALU_Op, Data_1, Data_2);

        // Release the stall and send two ops back to back.
        Out_Ready = 1'b1;
        drive(1'b1, 5'd6, 32'd77, 32'd88, 1'b0, 32'd0);
        #1;
        chk("b2b_in_ready", {31'd0, In_Ready}, 32'd1);
        tick();
        exp_cnt++;
        chk("b2b1_alu_op", {27'd0, ALU_Op}, 32'd6);
        chk("b2b1_data_1", Data_1, 32'd77);
        chk("b2b1_valid", {31'd0, Out_Valid}, 32'd1);
        chk("b2b1_count", 32'(Issue_Count), 32'(exp_cnt));
        drive(1'b1, 5'd7, 32'd1, 32'd2, 1'b1, 32'h12345678);
        tick();
        exp_cnt++;
        chk("b2b2_alu_op", {27'd0, ALU_Op}, 32'd7);
        chk("b2b2_data_2", Data_2, 32'h12345678);
        chk("b2b2_count", 32'(Issue_Count), 32'(exp_cnt));
        In_Valid = 1'b0;
        tick();
        exp_cnt++;
        chk("b2b_end_count", 32'(Issue_Count), 32'(exp_cnt));
        chk("b2b_end_valid", {31'd0, Out_Valid}, 32'd0);
        $display("back-to-back done count=%0d", Issue_Count);

        // Reset in the second SETTLE cycle of a DIV.
        drive(1'b1, 5'd3, 32'd50, 32'd5, 1'b0, 32'd0);
        tick();  // accept edge -> first settle cycle
        In_Valid = 1'b0;
        tick();  // second settle cycle
        chk("mid_settle_busy", {31'd0, Busy}, 32'd1);
        chk("mid_settle_valid", {31'd0, Out_Valid}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("reset_in_ready_comb", {31'd0, In_Ready}, 32'd0);
        tick();
        exp_cnt = 0;
        chk("rst_settle_alu_op", {27'd0, ALU_Op}, 32'd17);
        chk("rst_settle_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_settle_busy", {31'd0, Busy}, 32'd0);
        chk("rst_settle_count", 32'(Issue_Count), 32'd0);
        Reset = 1'b0;
        // Make sure the discarded DIV never reappears.
        tick();
        tick();
        tick();
        chk("rst_settle_no_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_settle_count2", 32'(Issue_Count), 32'd0);
        $display("reset mid-settle op=%0d valid=%0d count=%0d", ALU_Op, Out_Valid, Issue_Count);

`ifdef DIV_ZERO_TRAP_EN
        // A MOD with a zero divisor is trapped. The flag is sticky.
        chk("dz_initial", {31'd0, Div_Zero}, 32'd0);
        Out_Ready = 1'b0;
        drive(1'b1, 5'd4, 32'd13, 32'd0, 1'b0, 32'd0);
        tick();
        In_Valid = 1'b0;
        chk("dz_alu_op", {27'd0, ALU_Op}, 32'd17);
        chk("dz_valid", {31'd0, Out_Valid}, 32'd1);
        chk("dz_flag", {31'd0, Div_Zero}, 32'd1);
        chk("dz_data_1", Data_1, 32'd13);
        Out_Ready = 1'b1;
        drive(1'b1, 5'd0, 32'd1, 32'd2, 1'b0, 32'd0);
        tick();
        In_Valid = 1'b0;
        chk("dz_next_op", {27'd0, ALU_Op}, 32'd0);
        chk("dz_sticky", {31'd0, Div_Zero}, 32'd1);
        tick();
        chk("dz_sticky2", {31'd0, Div_Zero}, 32'd1);
        $display("div-zero trap flag=%0d", Div_Zero);
        do_reset();
        chk("dz_cleared", {31'd0, Div_Zero}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so that the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Issue stage directly upstream of the execute ALU.
- Registers the ALU opcode and both 32-bit operands. Applies the immediate select for Data_2.
- Holds values stable until the consumer accepts them, using a valid/ready handshake.
- DIV (3) and MOD (4) are multi-cycle paths. For these ops the stage holds operands stable for DIV_WAIT_CYCLES cycles before presenting them as valid, so the combinational divider can settle.

Parameters:
- DIV_WAIT_CYCLES, 4, cycles operands stay stable before Out_Valid for ops 3/4. Legal range 1..15; a value of 1 means no extra wait.
- CNT_W, 16, width of the Issue_Count statistics counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous reset, active-high.
- In_Valid  in  1  upstream holds a valid op.
- In_Ready  out  1  stage can accept this cycle.
- In_ALU_Op  in  5  opcode, 0..18 per the ALU opcode map.
- In_Data_1  in  32  operand 1.
- In_Data_2  in  32  operand 2 (register source).
- Imm_Sel  in  1  1: Data_2 takes Imm.
- Imm  in  32  immediate value.
- Out_Valid  out  1  ALU_Op/Data_1/Data_2 are valid and settled.
- Out_Ready  in  1  downstream consumes this cycle.
- ALU_Op  out  5  registered opcode to the ALU.
- Data_1  out  32  registered operand 1.
- Data_2  out  32  registered operand 2 (In_Data_2 or Imm).
- Busy  out  1  stage holds an op that has not been consumed.
- Issue_Count  out  CNT_W  number of completed output handshakes.

Behaviour:
- All state updates on the rising edge of Clock. Reset is synchronous, active-high.
- Reset values: ALU_Op=17 (NOP), Data_1=0, Data_2=0, Out_Valid=0, Busy=0, Issue_Count=0, state=IDLE, wait counter=0.
- In_Ready is forced to 0 while Reset is high.
- States:
  - IDLE: empty.
  - SETTLE: div/mod wait in progress.
  - HOLD: Out_Valid=1, waiting for Out_Ready.
- In_Ready = (state==IDLE) or (state==HOLD and Out_Ready). This is combinational from state and Out_Ready, with no dependency on In_Valid.
- Accept occurs when In_Valid and In_Ready are both 1. On accept:
  - Load ALU_Op=In_ALU_Op and Data_1=In_Data_1.
  - Load Data_2 = Imm_Sel ? Imm : In_Data_2.
- Routing after accept:
  - Op not 3/4, or DIV_WAIT_CYCLES==1: go to HOLD. Out_Valid=1 the cycle after accept, i.e. latency 1.
  - Op 3/4 and DIV_WAIT_CYCLES>1: go to SETTLE with wait counter=DIV_WAIT_CYCLES-1, Out_Valid=0. The counter decrements each cycle; when it reaches 0, go to HOLD.
  - Net result: Out_Valid rises DIV_WAIT_CYCLES cycles after the accept edge.
- HOLD with Out_Ready=1:
  - Handshake completes and Issue_Count increments, wrapping modulo 2^CNT_W.
  - If a new accept happens in the same cycle, load the new op (back-to-back, full throughput for non-div ops).
  - Otherwise go to IDLE and drop Out_Valid.
- HOLD with Out_Ready=0: all outputs are frozen.
- Outputs never change while Out_Valid=1 and Out_Ready=0.
- In SETTLE, Out_Ready is ignored and In_Ready=0.
- Busy = (state != IDLE).
- In IDLE, ALU_Op/Data_1/Data_2 retain their last values; the consumer qualifies them by Out_Valid.
- Opcodes 19..31 are passed through unmodified; the ALU default handles them.
- Reset in any state, including mid-SETTLE, returns to the reset values on the next edge. The in-flight op is discarded and not counted.

Optional Feature:
- Macro DIV_ZERO_TRAP_EN.
- Defined:
  - On accept of op 3 or 4 with a selected Data_2 of 0, the stage loads ALU_Op=17 (NOP) instead.
  - Data registers load as normal.
  - The SETTLE wait is skipped: go straight to HOLD.
  - A sticky output Div_Zero (1 bit, reset 0) is set to 1 and cleared only by Reset.
- Not defined:
  - The Div_Zero port does not exist.
  - Divide-by-zero ops issue unchanged with the normal wait.

Test Plan:
- Reset, then In_Valid=1, op=0, D1=5, D2=7, Out_Ready=1 -> next cycle Out_Valid=1, ALU_Op=0, Data_1=5, Data_2=7; Issue_Count=1 after the handshake.
- Op=3, D1=100, D2=7, DIV_WAIT_CYCLES=4 -> Out_Valid=0 for 3 cycles after accept, then 1 on the 4th; In_Ready=0 throughout SETTLE.
- Op=18, Imm_Sel=1, Imm=0xDEADBEEF, In_Data_2=0x1 -> Data_2=0xDEADBEEF.
- Out_Ready=0 held for 5 cycles while In_Valid=1 with changing inputs -> outputs frozen, In_Ready=0; on Out_Ready=1 the next op is loaded in the same cycle.
- Reset asserted in the 2nd SETTLE cycle of a DIV -> next edge ALU_Op=17, Out_Valid=0, Issue_Count unchanged at 0.
- DIV_ZERO_TRAP_EN defined, op=4, D2=0 -> next cycle ALU_Op=17, Out_Valid=1, Div_Zero=1 and staying 1 across later ops.
